// File: rtl/instruction_fetch_if.sv
// Bus between the fetch stage and its surroundings: instruction memory port,
// branch/stall control from later stages and the IF/ID register outputs.
interface instruction_fetch_if #(
    parameter int B = 32
);
    logic         PCSrc;
    logic [B-1:0] pc_branch;
    logic         stall;
    logic [B-1:0] imem_addr;
    logic [B-1:0] imem_data;
    logic [B-1:0] instruction;
    logic [B-1:0] pc_incrementado_out;
    logic         halted;

    modport master (
        input  PCSrc, pc_branch, stall, imem_data,
        output imem_addr, instruction, pc_incrementado_out, halted
    );

    modport slave (
        output PCSrc, pc_branch, stall, imem_data,
        input  imem_addr, instruction, pc_incrementado_out, halted
    );
endinterface

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: PC register, IF/ID pipeline register and RUN/HALT FSM.
// Optional IF_STEP_MODE_EN adds a step port; state then only updates on edges with step=1.
module instruction_fetch #(
    parameter int           B        = 32,
    parameter logic [B-1:0] RESET_PC = '0
) (
    input  logic clk,
    input  logic rst_n,
`ifdef IF_STEP_MODE_EN
    input  logic step,
`endif
    instruction_fetch_if.master bus
);

    typedef enum logic {RUN, HALT} state_t;

    localparam logic [B-1:0] PC_STEP   = B'(4);
    localparam logic [5:0]   HALT_OPC  = 6'b111111;

    state_t       state, state_next;
    logic [B-1:0] pc, pc_next;
    logic [B-1:0] instr_q, instr_next;
    logic [B-1:0] pc_inc_q, pc_inc_next;
    logic [B-1:0] pc_plus4;
    logic         update_en;

    assign pc_plus4 = pc + PC_STEP;

`ifdef IF_STEP_MODE_EN
    assign update_en = step;
`else
    assign update_en = 1'b1;
`endif

    // NOTE: every variable gets its hold value first so no path through this block infers a latch.
    always_comb begin
        state_next  = state;
        pc_next     = pc;
        instr_next  = instr_q;
        pc_inc_next = pc_inc_q;

        if (update_en) begin
            if (bus.PCSrc) begin
                // Redirect wins over stall and discards whatever is being fetched, halt opcode included.
                pc_next     = bus.pc_branch;
                instr_next  = '0;
                pc_inc_next = '0;
                state_next  = RUN;
            end else if (state == HALT) begin
                instr_next  = '0;
                pc_inc_next = '0;
            end else if (!bus.stall) begin
                instr_next  = bus.imem_data;
                pc_inc_next = pc_plus4;
                if (bus.imem_data[31:26] == HALT_OPC) begin
                    state_next = HALT;
                end else begin
                    pc_next = pc_plus4;
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments; reset is asynchronous and active-low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RUN;
            pc       <= RESET_PC;
            instr_q  <= '0;
            pc_inc_q <= '0;
        end else begin
            state    <= state_next;
            pc       <= pc_next;
            instr_q  <= instr_next;
            pc_inc_q <= pc_inc_next;
        end
    end

    assign bus.imem_addr           = pc;
    assign bus.instruction         = instr_q;
    assign bus.pc_incrementado_out = pc_inc_q;
    assign bus.halted              = (state == HALT);

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: table of per-edge vectors through a
// scoreboard queue, plus hand-written asynchronous reset sequences.
module tb_instruction_fetch;

    localparam int B = 32;

    typedef struct {
        logic        pcsrc;
        logic        stall;
        logic [31:0] branch;
        logic [31:0] exp_addr;
        logic [31:0] exp_instr;
        logic [31:0] exp_inc;
        logic        exp_halted;
    } vec_t;

    logic clk;
    logic rst_n;
`ifdef IF_STEP_MODE_EN
    logic step;
`endif

    int checks;
    int errors;

    vec_t vecs[$];
    vec_t exp_q[$];

    instruction_fetch_if #(.B(B)) bus ();

    instruction_fetch #(.B(B), .RESET_PC(32'h0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
`ifdef IF_STEP_MODE_EN
        .step  (step),
`endif
        .bus   (bus)
    );

    // Instruction memory: address-tagged words, with a halt opcode planted at 0x14.
    function automatic logic [31:0] word(input logic [31:0] a);
        if (a == 32'h14) return 32'hFC00_0000;
        return 32'h1000_0000 | (a & 32'h0FFF_FFFF);
    endfunction

    always_comb bus.imem_data = word(bus.imem_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic pcsrc, input logic stall, input logic [31:0] br);
        bus.PCSrc     = pcsrc;
        bus.stall     = stall;
        bus.pc_branch = br;
    endtask

    task automatic add(input logic pcsrc, input logic stall, input logic [31:0] br,
                       input logic [31:0] a, input logic [31:0] ins,
                       input logic [31:0] inc, input logic h);
        vec_t v;
        v.pcsrc = pcsrc; v.stall = stall; v.branch = br;
        v.exp_addr = a; v.exp_instr = ins; v.exp_inc = inc; v.exp_halted = h;
        vecs.push_back(v);
    endtask

    initial begin
        vec_t e;
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
`ifdef IF_STEP_MODE_EN
        step   = 1'b1;
`endif
        drive(1'b0, 1'b0, 32'h0);

        //  pcsrc stall branch        addr          instruction       pc+4          halted
        add(0, 0, 32'h0,          32'h04,       word(32'h00),     32'h04,       0);
        add(0, 0, 32'h0,          32'h08,       word(32'h04),     32'h08,       0);
        add(0, 1, 32'h0,          32'h08,       word(32'h04),     32'h08,       0);
        add(0, 1, 32'h0,          32'h08,       word(32'h04),     32'h08,       0);
        add(0, 0, 32'h0,          32'h0C,       word(32'h08),     32'h0C,       0);
        add(1, 1, 32'h40,         32'h40,       32'h0,            32'h0,        0);
        add(0, 0, 32'h0,          32'h44,       word(32'h40),     32'h44,       0);
        add(1, 0, 32'h10,         32'h10,       32'h0,            32'h0,        0);
        add(0, 0, 32'h0,          32'h14,       word(32'h10),     32'h14,       0);
        add(0, 0, 32'h0,          32'h14,       32'hFC00_0000,    32'h18,       1);
        add(0, 0, 32'h0,          32'h14,       32'h0,            32'h0,        1);
        add(0, 1, 32'h0,          32'h14,       32'h0,            32'h0,        1);
        add(1, 0, 32'h80,         32'h80,       32'h0,            32'h0,        0);
        add(0, 0, 32'h0,          32'h84,       word(32'h80),     32'h84,       0);
        add(1, 0, 32'hFFFF_FFFC,  32'hFFFF_FFFC, 32'h0,           32'h0,        0);
        add(0, 0, 32'h0,          32'h00,       32'h1FFF_FFFC,    32'h00,       0);
        add(1, 0, 32'h14,         32'h14,       32'h0,            32'h0,        0);
        add(1, 0, 32'h20,         32'h20,       32'h0,            32'h0,        0);
        add(0, 0, 32'h0,          32'h24,       word(32'h20),     32'h24,       0);

        #12;
        check("reset_addr",   bus.imem_addr, 32'h0);
        check("reset_instr",  bus.instruction, 32'h0);
        check("reset_inc",    bus.pc_incrementado_out, 32'h0);
        check("reset_halted", {31'b0, bus.halted}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].pcsrc, vecs[i].stall, vecs[i].branch);
            exp_q.push_back(vecs[i]);
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            check($sformatf("v%0d_addr", i),   bus.imem_addr, e.exp_addr);
            check($sformatf("v%0d_instr", i),  bus.instruction, e.exp_instr);
            check($sformatf("v%0d_inc", i),    bus.pc_incrementado_out, e.exp_inc);
            check($sformatf("v%0d_halted", i), {31'b0, bus.halted}, {31'b0, e.exp_halted});
        end

        // Reset while halted: must clear asynchronously, then fetch from RESET_PC.
        drive(1'b1, 1'b0, 32'h10);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 32'h0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("halt_entered", {31'b0, bus.halted}, 32'h1);
        rst_n = 1'b0;
        #1;
        check("rst_halt_addr",   bus.imem_addr, 32'h0);
        check("rst_halt_halted", {31'b0, bus.halted}, 32'h0);
        check("rst_halt_instr",  bus.instruction, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_addr",  bus.imem_addr, 32'h4);
        check("post_rst_instr", bus.instruction, word(32'h0));
        check("post_rst_inc",   bus.pc_incrementado_out, 32'h4);

        // Reset while stalled.
        drive(1'b0, 1'b1, 32'h0);
        @(posedge clk); #1;
        check("stall_hold_addr", bus.imem_addr, 32'h4);
        rst_n = 1'b0;
        #1;
        check("rst_stall_addr", bus.imem_addr, 32'h0);
        check("rst_stall_inc",  bus.pc_incrementado_out, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 32'h0);

`ifdef IF_STEP_MODE_EN
        step = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("step0_addr", bus.imem_addr, 32'h0);
        check("step0_instr", bus.instruction, 32'h0);
        @(negedge clk);
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("step_pulse_addr", bus.imem_addr, 32'h4);
        check("step_pulse_instr", bus.instruction, word(32'h0));
        rst_n = 1'b0;
        #1;
        check("step_rst_addr", bus.imem_addr, 32'h0);
        rst_n = 1'b1;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter B, default 32, width of PC, instruction and data words.
REQ-002 Parameter RESET_PC, default 0, PC value loaded by reset.
REQ-003 Clock and reset: one clock; reset is asynchronous and active-low (name the clock and reset ports as the codebase does; the polarity and synchronicity here are fixed).
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 reset  input  1  asynchronous active-low reset.
REQ-006 PCSrc  input  1  branch taken, from MEM stage; redirects fetch.
REQ-007 pc_branch  input  B  branch target address.
REQ-008 stall  input  1  hazard stall; holds PC and IF/ID register.
REQ-009 imem_addr  output  B  instruction memory address; equals current PC combinationally.
REQ-010 imem_data  input  B  instruction word at imem_addr; combinational read, valid same cycle.
REQ-011 instruction  output  B  IF/ID registered instruction, feeds decode stage.
REQ-012 pc_incrementado_out  output  B  IF/ID registered PC+4 of that instruction.
REQ-013 halted  output  1  high while fetch is in HALT state.
REQ-014 step  input  1  single-step enable; present only when IF_STEP_MODE_EN is defined.

Function
REQ-015 PC register, width B; pc_next = PC + 4, modulo 2^B (0xFFFFFFFC + 4 = 0x00000000).
REQ-016 FSM states RUN and HALT; reset state RUN.
REQ-017 Per-edge priority: PCSrc > stall > halt detection > normal advance.
REQ-018 RUN, normal: PC <= PC+4; instruction <= imem_data; pc_incrementado_out <= PC+4.
REQ-019 PCSrc=1 (any state, regardless of stall): PC <= pc_branch; instruction <= 0 (NOP); pc_incrementado_out <= 0; state <= RUN.
REQ-020 stall=1, PCSrc=0: PC, instruction, pc_incrementado_out and state unchanged.
REQ-021 Halt detection: in RUN with PCSrc=0, stall=0 and imem_data[31:26] = 6'b111111: IF/ID loads as per REQ-018, PC unchanged, state <= HALT.
REQ-022 HALT with PCSrc=0: PC held; instruction <= 0; pc_incrementado_out <= 0; stall ignored.
REQ-023 halted = 1 exactly when state is HALT (registered, no combinational path from imem_data).
REQ-024 Latency: instruction fetched at PC appears on instruction one clock edge after imem_addr = PC.
REQ-025 A halt opcode fetched in the same cycle as PCSrc=1 is discarded; no HALT entry.

Reset
REQ-026 reset low asynchronously forces PC = RESET_PC, instruction = 0, pc_incrementado_out = 0, state = RUN, halted = 0.
REQ-027 Reset asserted mid-stall, mid-branch or in HALT has the same effect; first fetch after release is from RESET_PC on the first rising edge with reset high.

Configuration
REQ-028 Macro IF_STEP_MODE_EN: when defined, port step exists and every PC, IF/ID and FSM update (including PCSrc redirect) occurs only on edges where step=1; with step=0 all state holds.
REQ-029 Without IF_STEP_MODE_EN: no step port; behaviour per REQ-015..REQ-025 every edge.

Verification
REQ-030 Reset release, imem returns addr-indexed words, 3 clocks -> imem_addr 0,4,8,12; pc_incrementado_out 4,8,12; instruction tracks imem_data one cycle late.
REQ-031 PCSrc=1, pc_branch=0x40 at PC=0x10 -> next PC 0x40, instruction 0, pc_incrementado_out 0; following edge instruction = word at 0x40.
REQ-032 stall=1 two cycles at PC=0x8 -> imem_addr and IF/ID outputs frozen; stall=1 with PCSrc=1 -> branch taken.
REQ-033 imem_data=0xFC000000 at PC=0x14 -> instruction=0xFC000000, halted=1, PC stays 0x14, next edge instruction=0; PCSrc=1 to 0x80 -> halted=0, PC 0x80.
REQ-034 PC=0xFFFFFFFC normal advance -> PC 0x00000000, pc_incrementado_out 0x00000000.
REQ-035 With IF_STEP_MODE_EN: step=0 for 5 clocks -> no change; one-cycle step pulse -> exactly one PC advance; reset low mid-sequence -> PC=0 immediately, without waiting for clk.
